// File: rtl/spi_fl_req_arbiter.sv
// rtl/spi_fl_req_arbiter.sv - cache/software request arbiter in front of the SPI flash master
module spi_fl_req_arbiter #(
    parameter int                   DATA_W         = 32,
    parameter int                   CACHE_ADDR_W   = 25,
    parameter logic [31:0]          FL_BASE        = 32'h0,
    parameter int                   TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_cache,
    input  logic [CACHE_ADDR_W-1:0] address_cache,
    input  logic [3:0]              wstrb_cache,
    output logic [DATA_W-1:0]       rdata_cache,
    output logic                    ready_cache,
    output logic                    err_cache,
    input  logic                    sw_valid,
    input  logic [31:0]             sw_address,
    output logic [DATA_W-1:0]       sw_rdata,
    output logic                    sw_done,
    output logic                    sw_busy,
    output logic                    sw_timeout,
    output logic                    fl_valid,
    output logic [31:0]             fl_address,
    output logic                    fl_cache_sel,
    input  logic                    fl_ready,
    input  logic [DATA_W-1:0]       fl_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  sw_pend_q, sw_pend_d;
    logic [31:0]           sw_addr_q, sw_addr_d;
    logic [31:0]           fl_addr_q, fl_addr_d;
    logic                  cache_sel_q, cache_sel_d;
    logic                  last_cache_q, last_cache_d;
    logic                  seen_busy_q, seen_busy_d;
    logic [TIMEOUT_W-1:0]  wdog_q, wdog_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     rdata_cache_q, rdata_cache_d;
    logic [DATA_W-1:0]     sw_rdata_q, sw_rdata_d;
    logic                  sw_timeout_q, sw_timeout_d;

    logic                  sw_inflight;
    logic                  sw_accept;
    logic                  grant_cache;
    logic                  grant_sw;
    logic [TIMEOUT_W-1:0]  wdog_inc;
    logic [31:0]           cache_fl_addr;
    logic                  unused_addr_lsb;

    assign sw_inflight   = (state_q != S_IDLE) && !cache_sel_q;
    assign sw_accept     = sw_valid && !sw_pend_q && !sw_inflight;
    // On a tie the source that did not win last time gets the grant.
    assign grant_cache   = valid_cache && (!sw_pend_q || !last_cache_q);
    assign grant_sw      = sw_pend_q && !grant_cache;
    assign wdog_inc      = wdog_q + 1'b1;
    assign cache_fl_addr = FL_BASE + {{(32-CACHE_ADDR_W){1'b0}},
                                      address_cache[CACHE_ADDR_W-1:2], 2'b00};
    assign unused_addr_lsb = &{1'b0, address_cache[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            sw_pend_q     <= 1'b0;
            sw_addr_q     <= '0;
            fl_addr_q     <= '0;
            cache_sel_q   <= 1'b0;
            last_cache_q  <= 1'b0;
            seen_busy_q   <= 1'b0;
            wdog_q        <= '0;
            err_q         <= 1'b0;
            rdata_cache_q <= '0;
            sw_rdata_q    <= '0;
            sw_timeout_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sw_pend_q     <= sw_pend_d;
            sw_addr_q     <= sw_addr_d;
            fl_addr_q     <= fl_addr_d;
            cache_sel_q   <= cache_sel_d;
            last_cache_q  <= last_cache_d;
            seen_busy_q   <= seen_busy_d;
            wdog_q        <= wdog_d;
            err_q         <= err_d;
            rdata_cache_q <= rdata_cache_d;
            sw_rdata_q    <= sw_rdata_d;
            sw_timeout_q  <= sw_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sw_pend_d     = sw_pend_q;
        sw_addr_d     = sw_addr_q;
        fl_addr_d     = fl_addr_q;
        cache_sel_d   = cache_sel_q;
        last_cache_d  = last_cache_q;
        seen_busy_d   = seen_busy_q;
        wdog_d        = wdog_q;
        err_d         = err_q;
        rdata_cache_d = rdata_cache_q;
        sw_rdata_d    = sw_rdata_q;
        sw_timeout_d  = sw_timeout_q;

        if (sw_valid) begin
            sw_timeout_d = 1'b0;
        end
        if (sw_accept) begin
            sw_pend_d = 1'b1;
            sw_addr_d = sw_address;
        end

        case (state_q)
            S_IDLE: begin
                if (grant_cache) begin
                    cache_sel_d = 1'b1;
                    // Cache writes are answered with an error and never reach the flash.
                    if (wstrb_cache != 4'h0) begin
                        err_d         = 1'b1;
                        rdata_cache_d = '0;
                        state_d       = S_RESP;
                    end else begin
                        fl_addr_d = cache_fl_addr;
                        state_d   = S_ISSUE;
                    end
                end else if (grant_sw) begin
                    cache_sel_d = 1'b0;
                    fl_addr_d   = sw_addr_q;
                    sw_pend_d   = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                seen_busy_d = 1'b0;
                wdog_d      = '0;
                err_d       = 1'b0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_inc;
                // A ready seen before the controller has gone busy is left over from idle.
                if (fl_ready && seen_busy_q) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                    if (cache_sel_q) begin
                        rdata_cache_d = fl_rdata;
                    end else begin
                        sw_rdata_d   = fl_rdata;
                        sw_timeout_d = 1'b0;
                    end
                end else if (wdog_inc == TIMEOUT_CYCLES) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                    if (cache_sel_q) begin
                        rdata_cache_d = '0;
                    end else begin
                        sw_rdata_d   = '0;
                        sw_timeout_d = 1'b1;
                    end
                end else if (!fl_ready) begin
                    seen_busy_d = 1'b1;
                end
            end
            S_RESP: begin
                last_cache_d = cache_sel_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fl_valid     = (state_q == S_ISSUE);
        fl_address   = fl_addr_q;
        fl_cache_sel = cache_sel_q;
        ready_cache  = (state_q == S_RESP) && cache_sel_q;
        err_cache    = (state_q == S_RESP) && cache_sel_q && err_q;
        rdata_cache  = rdata_cache_q;
        sw_done      = (state_q == S_RESP) && !cache_sel_q;
        sw_rdata     = sw_rdata_q;
        sw_busy      = sw_pend_q || sw_inflight;
        sw_timeout   = sw_timeout_q;
    end

endmodule
